btb_ram_ctrl: RTL and testbench
===============================

Name: btb_ram_ctrl

Overview:
- Sequencer/arbiter in front of the BTB true-dual-port byte-enabled RAM macro (56-bit entries, 128 deep).
- Owns both RAM ports:
  - port A serves fetch-side lookups (read-only);
  - port B drains a small update queue fed by execute-stage branch resolution.
- After reset or flush, walks every address writing zeros, and handles the same-cycle read/write address collision by forwarding.

Parameters:
- DATA_WIDTH, 56, BTB entry width in bits; must be a multiple of 8.
- ADDR_WIDTH, 7, RAM address width (128 entries).
- BYTE_EN, DATA_WIDTH/8, byte-enable width.
- UQ_DEPTH, 4, update queue depth; power of 2, at least 2.

Ports:
- clk  in  1  single clock; drives the RAM's clka and clkb
- rst_n  in  1  asynchronous active-low reset
- flush_i  in  1  invalidate whole BTB
- lookup_valid_i  in  1  fetch lookup request
- lookup_addr_i  in  ADDR_WIDTH  lookup index
- lookup_ready_o  out  1  lookup accepted this cycle
- lookup_rdata_valid_o  out  1  lookup data valid (1 cycle after accept)
- lookup_rdata_o  out  DATA_WIDTH  lookup data
- upd_valid_i  in  1  update request
- upd_ready_o  out  1  update accepted
- upd_addr_i  in  ADDR_WIDTH  update index
- upd_data_i  in  DATA_WIDTH  update data
- upd_be_i  in  BYTE_EN  update byte enables
- busy_o  out  1  clear walk in progress
- ram_ena_o  out  1  RAM enable (shared by both ports)
- ram_wea_o  out  BYTE_EN  port A write enables; always 0
- ram_addra_o  out  ADDR_WIDTH  port A address
- ram_douta_i  in  DATA_WIDTH  port A read data
- ram_web_o  out  BYTE_EN  port B write enables
- ram_addrb_o  out  ADDR_WIDTH  port B address
- ram_dinb_o  out  DATA_WIDTH  port B write data

Behaviour:
- RAM rsta/rstb are tied 0 at integration. ram_dina is unused.
- ram_ena_o = 1 in CLEAR, and in RUN when a lookup is accepted or a queue entry is popped.

State machine (states CLEAR, RUN):
- Asynchronous reset state: CLEAR with clr_cnt = 0.
- In CLEAR:
  - port B writes 0 to address clr_cnt with web all-ones every cycle; clr_cnt increments.
  - After the write to address 2^ADDR_WIDTH-1, go to RUN. The walk takes exactly 128 cycles at default.
- In RUN:
  - flush_i = 1 goes to CLEAR with clr_cnt = 0 and empties the update queue; queued entries are discarded.
  - flush_i asserted during CLEAR restarts clr_cnt at 0.
  - In both cases flush has priority over every other event that cycle.
- Reset values:
  - busy_o = 1 (busy_o = 1 iff state == CLEAR).
  - lookup_ready_o = 0, upd_ready_o = 0, lookup_rdata_valid_o = 0.
  - lookup_rdata_o = 0.
  - Queue empty.

Lookup (port A):
- lookup_ready_o = 1 iff state == RUN and flush_i == 0.
- Accept = lookup_valid_i & lookup_ready_o. On accept, ram_addra_o = lookup_addr_i.
- Next cycle, lookup_rdata_valid_o = 1 and lookup_rdata_o is valid. Latency is 1 cycle, 1 lookup per cycle, no back-pressure in RUN.
- lookup_rdata_o holds its last value when lookup_rdata_valid_o = 0.
- A flush in the cycle after an accept does not suppress that cycle's rdata_valid.

Update queue:
- FIFO of {addr, data, be}, UQ_DEPTH entries, with a registered count.
- upd_ready_o = 1 iff state == RUN and count < UQ_DEPTH. A same-cycle pop does not raise ready.
- Push = upd_valid_i & upd_ready_o.
- In RUN, when count > 0, pop the head every cycle: ram_web_o = head.be, ram_addrb_o = head.addr, ram_dinb_o = head.data.
  - A head with be = 0 is popped with no write.
- Push and pop in the same cycle is legal; count is unchanged.
- An entry pushed at cycle t is written no earlier than t+1.
- Lookups do not search the queue; stale reads of pending updates are acceptable.

Collision forwarding:
- Condition: an accepted lookup address equals a port B write address in the same cycle. This applies in RUN only.
- Register fwd_hit, fwd_be, fwd_data.
- Next cycle, each byte i of lookup_rdata_o = fwd_be[i] ? fwd_data byte i : ram_douta_i byte i.
- Without a hit, lookup_rdata_o = ram_douta_i.

Decomposition:
- Package btb_pkg holds:
  - BTB_DATA_WIDTH = 56, BTB_ADDR_WIDTH = 7, BTB_BYTE_EN;
  - state enum {CLEAR, RUN};
  - update-entry struct {addr, data, be}.
- One sub-module: btb_upd_fifo. Parameterised synchronous FIFO with push, pop, full, empty, count and a synchronous clear; same clk/rst_n.

Test Plan:
- Reset release -> busy_o = 1 for exactly 128 cycles, ram_web_o = 7'h7F with addresses 0..127 ascending, then lookup_ready_o = 1 and upd_ready_o = 1.
- Update addr 5, data 56'h11223344556677, be 7'h7F; then lookup addr 5 two cycles later -> lookup_rdata_o = 56'h11223344556677 one cycle after accept.
- Partial write be = 7'h01, data 0xAB to addr 5 (holding the value above) -> lookup returns 56'h112233445566AB.
- Lookup addr 9 in the same cycle the head writes addr 9 with data 56'hFF..FF, be 7'h0F -> returned data 56'h000000FFFFFFFF (forwarded low 4 bytes, zeros above).
- Push 5 updates back-to-back while the queue drains -> no overflow, every update written in order, upd_ready_o never high when count == UQ_DEPTH.
- Assert flush_i with 3 queued updates, then re-assert at clear cycle 60 -> queue discarded, walk restarts at 0, busy_o high 128 cycles after the last flush, and all lookups then return 0.

Source files
------------

// File: rtl/btb_pkg.sv
// Shared types and constants for the BTB RAM sequencer.
package btb_pkg;

  localparam int BTB_DATA_WIDTH = 56;
  localparam int BTB_ADDR_WIDTH = 7;
  localparam int BTB_BYTE_EN    = BTB_DATA_WIDTH / 8;
  localparam int BTB_UQ_DEPTH   = 4;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } btb_state_e;

  typedef struct packed {
    logic [BTB_ADDR_WIDTH-1:0] addr;
    logic [BTB_DATA_WIDTH-1:0] data;
    logic [BTB_BYTE_EN-1:0]    be;
  } btb_upd_t;

  localparam int BTB_UPD_WIDTH = $bits(btb_upd_t);

  // Byte-wise select: bytes flagged in sel come from new_d, the rest from old_d.
  function automatic logic [BTB_DATA_WIDTH-1:0] btb_byte_merge(
    input logic [BTB_BYTE_EN-1:0]    sel,
    input logic [BTB_DATA_WIDTH-1:0] new_d,
    input logic [BTB_DATA_WIDTH-1:0] old_d
  );
    logic [BTB_DATA_WIDTH-1:0] res;
    res = old_d;
    for (int i = 0; i < BTB_BYTE_EN; i++) begin
      if (sel[i]) begin
        res[i*8 +: 8] = new_d[i*8 +: 8];
      end else begin
        res[i*8 +: 8] = old_d[i*8 +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/btb_upd_fifo.sv
// Small synchronous FIFO for pending BTB updates, with a synchronous clear
// that wins over push and pop in the same cycle.
module btb_upd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 70
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_clr,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == CW'(0));
  assign o_count   = r_count;
  assign o_head    = r_mem[r_rd_ptr];
  assign w_do_push = i_push & ~o_full & ~i_clr;
  assign w_do_pop  = i_pop & ~o_empty & ~i_clr;

  // Pointer and occupancy bookkeeping; clear empties the queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/btb_ram_ctrl.sv
// Sequencer in front of the dual-port BTB RAM: port A serves fetch lookups,
// port B drains the update queue, and a clear walk zeroes the array after
// reset or flush. Same-address lookup/write collisions are forwarded.
module btb_ram_ctrl
  import btb_pkg::*;
#(
  parameter int DATA_WIDTH = BTB_DATA_WIDTH,
  parameter int ADDR_WIDTH = BTB_ADDR_WIDTH,
  parameter int BYTE_EN    = DATA_WIDTH / 8,
  parameter int UQ_DEPTH   = BTB_UQ_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_i,
  input  logic                  lookup_valid_i,
  input  logic [ADDR_WIDTH-1:0] lookup_addr_i,
  output logic                  lookup_ready_o,
  output logic                  lookup_rdata_valid_o,
  output logic [DATA_WIDTH-1:0] lookup_rdata_o,
  input  logic                  upd_valid_i,
  output logic                  upd_ready_o,
  input  logic [ADDR_WIDTH-1:0] upd_addr_i,
  input  logic [DATA_WIDTH-1:0] upd_data_i,
  input  logic [BYTE_EN-1:0]    upd_be_i,
  output logic                  busy_o,
  output logic                  ram_ena_o,
  output logic [BYTE_EN-1:0]    ram_wea_o,
  output logic [ADDR_WIDTH-1:0] ram_addra_o,
  input  logic [DATA_WIDTH-1:0] ram_douta_i,
  output logic [BYTE_EN-1:0]    ram_web_o,
  output logic [ADDR_WIDTH-1:0] ram_addrb_o,
  output logic [DATA_WIDTH-1:0] ram_dinb_o
);

  localparam int CW = $clog2(UQ_DEPTH) + 1;
  localparam logic [ADDR_WIDTH-1:0] CLR_LAST = {ADDR_WIDTH{1'b1}};

  btb_state_e            r_state;
  btb_state_e            w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_clr_cnt;
  logic [ADDR_WIDTH-1:0] w_clr_cnt_nxt;

  btb_upd_t              w_push_entry;
  btb_upd_t              w_head;
  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic [CW-1:0]         w_fifo_count;

  logic                  w_run;
  logic                  w_lookup_acc;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_fwd_hit;
  logic [DATA_WIDTH-1:0] w_rdata_merged;

  logic                  r_lookup_vld;
  logic                  r_fwd_hit;
  logic [BYTE_EN-1:0]    r_fwd_be;
  logic [DATA_WIDTH-1:0] r_fwd_data;
  logic [DATA_WIDTH-1:0] r_rdata_hold;

  assign w_run          = (r_state == ST_RUN);
  assign busy_o         = ~w_run;
  assign lookup_ready_o = w_run & ~flush_i;
  assign upd_ready_o    = w_run & (w_fifo_count < CW'(UQ_DEPTH));
  assign w_lookup_acc   = lookup_valid_i & lookup_ready_o;
  // Flush discards anything offered in the same cycle.
  assign w_push         = upd_valid_i & w_run & ~w_fifo_full & ~flush_i;
  assign w_pop          = w_run & ~flush_i & ~w_fifo_empty;
  assign w_fwd_hit      = w_lookup_acc & w_pop & (|w_head.be) &
                          (w_head.addr == lookup_addr_i);

  assign w_push_entry.addr = upd_addr_i;
  assign w_push_entry.data = upd_data_i;
  assign w_push_entry.be   = upd_be_i;

  assign ram_wea_o   = '0;
  assign ram_addra_o = lookup_addr_i;

  btb_upd_fifo #(
    .DEPTH (UQ_DEPTH),
    .WIDTH (BTB_UPD_WIDTH)
  ) u_upd_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (flush_i),
    .i_push  (w_push),
    .i_data  (w_push_entry),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  // State and clear-walk counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_CLEAR;
      r_clr_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_cnt <= w_clr_cnt_nxt;
    end
  end

  // Next-state logic: flush always restarts the walk from address 0.
  always_comb begin
    w_state_nxt   = r_state;
    w_clr_cnt_nxt = r_clr_cnt;
    case (r_state)
      ST_CLEAR: begin
        if (flush_i) begin
          w_clr_cnt_nxt = '0;
        end else if (r_clr_cnt == CLR_LAST) begin
          w_state_nxt   = ST_RUN;
          w_clr_cnt_nxt = '0;
        end else begin
          w_clr_cnt_nxt = r_clr_cnt + ADDR_WIDTH'(1);
        end
      end
      ST_RUN: begin
        if (flush_i) begin
          w_state_nxt   = ST_CLEAR;
          w_clr_cnt_nxt = '0;
        end else begin
          w_state_nxt   = ST_RUN;
        end
      end
      default: begin
        w_state_nxt   = ST_CLEAR;
        w_clr_cnt_nxt = '0;
      end
    endcase
  end

  // RAM port drive: zero-walk in CLEAR, queue head in RUN.
  always_comb begin
    ram_ena_o   = 1'b0;
    ram_web_o   = '0;
    ram_addrb_o = w_head.addr;
    ram_dinb_o  = w_head.data;
    case (r_state)
      ST_CLEAR: begin
        ram_ena_o   = 1'b1;
        ram_web_o   = {BYTE_EN{1'b1}};
        ram_addrb_o = r_clr_cnt;
        ram_dinb_o  = '0;
      end
      ST_RUN: begin
        ram_ena_o = w_pop | w_lookup_acc;
        if (w_pop) begin
          ram_web_o = w_head.be;
        end else begin
          ram_web_o = '0;
        end
      end
      default: begin
        ram_ena_o = 1'b0;
      end
    endcase
  end

  // Lookup pipeline: remember the accept and any same-cycle write to forward.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lookup_vld <= 1'b0;
      r_fwd_hit    <= 1'b0;
      r_fwd_be     <= '0;
      r_fwd_data   <= '0;
    end else begin
      r_lookup_vld <= w_lookup_acc;
      if (w_lookup_acc) begin
        r_fwd_hit  <= w_fwd_hit;
        r_fwd_be   <= w_head.be;
        r_fwd_data <= w_head.data;
      end
    end
  end

  // The RAM reads old data on a collision, so written bytes are patched in.
  always_comb begin
    if (r_fwd_hit) begin
      w_rdata_merged = btb_byte_merge(r_fwd_be, r_fwd_data, ram_douta_i);
    end else begin
      w_rdata_merged = ram_douta_i;
    end
  end

  // Last returned lookup data, presented while no new result is valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata_hold <= '0;
    end else if (r_lookup_vld) begin
      r_rdata_hold <= w_rdata_merged;
    end
  end

  // Result mux: fresh data on the valid cycle, held value otherwise.
  always_comb begin
    if (r_lookup_vld) begin
      lookup_rdata_o = w_rdata_merged;
    end else begin
      lookup_rdata_o = r_rdata_hold;
    end
  end

  assign lookup_rdata_valid_o = r_lookup_vld;

endmodule

// File: tb/tb_btb_ram_ctrl.sv
// Bench for btb_ram_ctrl: behavioural RAM plus a reference model holding the
// architectural BTB contents and the pending update list.
module tb_btb_ram_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush_i = 1'b0;
  logic        lookup_valid_i = 1'b0;
  logic [6:0]  lookup_addr_i = '0;
  logic        lookup_ready_o;
  logic        lookup_rdata_valid_o;
  logic [55:0] lookup_rdata_o;
  logic        upd_valid_i = 1'b0;
  logic        upd_ready_o;
  logic [6:0]  upd_addr_i = '0;
  logic [55:0] upd_data_i = '0;
  logic [6:0]  upd_be_i = '0;
  logic        busy_o;
  logic        ram_ena_o;
  logic [6:0]  ram_wea_o;
  logic [6:0]  ram_addra_o;
  logic [55:0] ram_douta_i = '0;
  logic [6:0]  ram_web_o;
  logic [6:0]  ram_addrb_o;
  logic [55:0] ram_dinb_o;

  btb_ram_ctrl dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .flush_i              (flush_i),
    .lookup_valid_i       (lookup_valid_i),
    .lookup_addr_i        (lookup_addr_i),
    .lookup_ready_o       (lookup_ready_o),
    .lookup_rdata_valid_o (lookup_rdata_valid_o),
    .lookup_rdata_o       (lookup_rdata_o),
    .upd_valid_i          (upd_valid_i),
    .upd_ready_o          (upd_ready_o),
    .upd_addr_i           (upd_addr_i),
    .upd_data_i           (upd_data_i),
    .upd_be_i             (upd_be_i),
    .busy_o               (busy_o),
    .ram_ena_o            (ram_ena_o),
    .ram_wea_o            (ram_wea_o),
    .ram_addra_o          (ram_addra_o),
    .ram_douta_i          (ram_douta_i),
    .ram_web_o            (ram_web_o),
    .ram_addrb_o          (ram_addrb_o),
    .ram_dinb_o           (ram_dinb_o)
  );

  always #5 clk = ~clk;

  // Behavioural RAM macro: read-first on port A, byte-enabled writes on port B.
  logic [55:0] ram [128];
  always @(posedge clk) begin
    if (ram_ena_o) begin
      ram_douta_i <= ram[ram_addra_o];
      for (int b = 0; b < 7; b++) begin
        if (ram_web_o[b]) ram[ram_addrb_o][b*8 +: 8] <= ram_dinb_o[b*8 +: 8];
      end
    end
  end

  typedef struct {
    logic [6:0]  a;
    logic [55:0] d;
    logic [6:0]  be;
  } upd_t;

  int          n_tests = 0;
  int          n_fail = 0;
  bit          m_run = 1'b0;
  int          m_clr = 0;
  upd_t        q[$];
  logic [55:0] ref_mem [128];
  logic [55:0] last_exp = '0;
  logic        obs_busy;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle of stimulus, checked against the reference model.
  task automatic step(input logic f, input logic lv, input logic [6:0] la,
                      input logic uv, input logic [6:0] ua, input logic [55:0] ud,
                      input logic [6:0] ube);
    logic exp_lr, exp_ur, acc, psh, do_pop;
    upd_t h, e;
    flush_i = f; lookup_valid_i = lv; lookup_addr_i = la;
    upd_valid_i = uv; upd_addr_i = ua; upd_data_i = ud; upd_be_i = ube;
    @(negedge clk);
    exp_lr = m_run && !f;
    exp_ur = m_run && (q.size() < 4);
    acc    = lv && exp_lr;
    psh    = uv && exp_ur;
    do_pop = m_run && !f && (q.size() > 0);
    obs_busy = busy_o;
    chk("busy", {63'd0, busy_o}, {63'd0, !m_run});
    chk("lookup_ready", {63'd0, lookup_ready_o}, {63'd0, exp_lr});
    chk("upd_ready", {63'd0, upd_ready_o}, {63'd0, exp_ur});
    chk("wea", {57'd0, ram_wea_o}, 64'd0);
    if (!m_run) begin
      chk("clr_ena", {63'd0, ram_ena_o}, 64'd1);
      chk("clr_web", {57'd0, ram_web_o}, 64'h7F);
      chk("clr_addrb", {57'd0, ram_addrb_o}, 64'(m_clr));
      chk("clr_dinb", {8'd0, ram_dinb_o}, 64'd0);
    end else if (do_pop) begin
      h = q[0];
      chk("pop_ena", {63'd0, ram_ena_o}, 64'd1);
      chk("pop_web", {57'd0, ram_web_o}, {57'd0, h.be});
      chk("pop_addrb", {57'd0, ram_addrb_o}, {57'd0, h.a});
      chk("pop_dinb", {8'd0, ram_dinb_o}, {8'd0, h.d});
    end else begin
      chk("idle_ena", {63'd0, ram_ena_o}, {63'd0, acc});
      chk("idle_web", {57'd0, ram_web_o}, 64'd0);
    end
    if (acc) chk("addra", {57'd0, ram_addra_o}, {57'd0, la});
    // Reference model: architectural contents after this cycle's write.
    if (!m_run) begin
      if (f) m_clr = 0;
      else begin
        ref_mem[m_clr] = '0;
        if (m_clr == 127) begin m_run = 1'b1; m_clr = 0; end
        else m_clr++;
      end
    end else if (f) begin
      m_run = 1'b0; m_clr = 0; q.delete();
    end else begin
      if (do_pop) begin
        h = q.pop_front();
        for (int b = 0; b < 7; b++)
          if (h.be[b]) ref_mem[h.a][b*8 +: 8] = h.d[b*8 +: 8];
      end
      if (psh) begin
        e.a = ua; e.d = ud; e.be = ube;
        q.push_back(e);
      end
    end
    if (acc) last_exp = ref_mem[la];
    @(posedge clk); #1;
    chk("rdata_valid", {63'd0, lookup_rdata_valid_o}, {63'd0, acc});
    chk("rdata", {8'd0, lookup_rdata_o}, {8'd0, last_exp});
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 7'd0, 1'b0, 7'd0, 56'd0, 7'd0);
  endtask

  task automatic lookup(input logic [6:0] a);
    step(1'b0, 1'b1, a, 1'b0, 7'd0, 56'd0, 7'd0);
  endtask

  task automatic update(input logic [6:0] a, input logic [55:0] d, input logic [6:0] be);
    step(1'b0, 1'b0, 7'd0, 1'b1, a, d, be);
  endtask

  // Counts busy cycles from now until RUN is reached, bounded.
  task automatic count_busy(input string tag);
    int n = 0;
    for (int k = 0; k < 300; k++) begin
      idle();
      if (obs_busy) n++;
      else break;
    end
    chk(tag, 64'(n), 64'd128);
  endtask

  initial begin
    logic [63:0] rnd;
    for (int i = 0; i < 128; i++) begin
      ram[i] = {$urandom(), $urandom()} >> 8;
      ref_mem[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {63'd0, busy_o}, 64'd1);
    chk("rst_lready", {63'd0, lookup_ready_o}, 64'd0);
    chk("rst_uready", {63'd0, upd_ready_o}, 64'd0);
    chk("rst_rvalid", {63'd0, lookup_rdata_valid_o}, 64'd0);
    chk("rst_rdata", {8'd0, lookup_rdata_o}, 64'd0);
    rst_n = 1'b1;

    count_busy("walk_after_reset");
    chk("run_lready", {63'd0, lookup_ready_o}, 64'd1);
    chk("run_uready", {63'd0, upd_ready_o}, 64'd1);

    // Full write then lookup.
    update(7'd5, 56'h11223344556677, 7'h7F);
    idle();
    lookup(7'd5);
    chk("full_write", {8'd0, lookup_rdata_o}, 64'h0011223344556677);

    // Partial byte write.
    update(7'd5, 56'h000000000000AB, 7'h01);
    idle();
    lookup(7'd5);
    chk("partial_write", {8'd0, lookup_rdata_o}, 64'h00112233445566AB);
    idle();
    chk("hold", {8'd0, lookup_rdata_o}, 64'h00112233445566AB);

    // Collision: lookup in the same cycle the head writes the same address.
    update(7'd9, 56'hFFFFFFFFFFFFFF, 7'h0F);
    lookup(7'd9);
    chk("collision", {8'd0, lookup_rdata_o}, 64'h000000FFFFFFFF);

    // Back-to-back updates while the queue drains.
    for (int i = 0; i < 5; i++)
      update(7'(20 + i), {8'(i + 1), 48'h0A0B0C0D0E0F}, 7'h7F);
    idle();
    for (int i = 0; i < 5; i++) begin
      lookup(7'(20 + i));
      chk("b2b", {8'd0, lookup_rdata_o}, {8'd0, 8'(i + 1), 48'h0A0B0C0D0E0F});
    end

    // Flush with updates in flight, re-flush mid-walk.
    update(7'd30, 56'h3030303030, 7'h7F);
    update(7'd31, 56'h3131313131, 7'h7F);
    step(1'b1, 1'b0, 7'd0, 1'b1, 7'd32, 56'h3232323232, 7'h7F);
    for (int i = 0; i < 60; i++) idle();
    step(1'b1, 1'b0, 7'd0, 1'b0, 7'd0, 56'd0, 7'd0);
    count_busy("walk_after_flush");
    for (int i = 0; i < 4; i++) begin
      lookup(7'(i == 3 ? 5 : 30 + i));
      chk("post_flush_zero", {8'd0, lookup_rdata_o}, 64'd0);
    end

    // Randomised traffic with frequent address collisions.
    for (int i = 0; i < 1500; i++) begin
      rnd = {$urandom(), $urandom()};
      step(($urandom_range(0, 299) == 0), 1'($urandom_range(0, 1)),
           7'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
           7'($urandom_range(0, 15)), rnd[55:0], 7'($urandom_range(0, 127)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
